// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared BE types for the BE->FE command path
//
// Purpose: processor configuration selector, the FE command layout, the
// command-arbiter FSM encoding, the safe clog2 helper and the credit-bound
// assertion helper macro.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

// Credit bounds: a dequeue may only happen while something is queued, and an
// enqueue is never issued against a registered count of zero free entries.
`ifndef BP_BE_CRED_BOUNDS_ASSERT
`define BP_BE_CRED_BOUNDS_ASSERT(clk, rst, cred, els, v, deq) \
  assert property (@(posedge clk) disable iff (rst) !((deq) && ((cred) == (els)))); \
  assert property (@(posedge clk) disable iff (rst) !((v) && ((cred) == '0)));
`endif

package bp_be_pkg;

  typedef enum logic {
    e_bp_default_cfg
  } bp_params_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [28:0] operand;
  } bp_fe_cmd_s;

  typedef enum logic [1:0] {
    e_run,
    e_wait_empty,
    e_wait_deq
  } bp_be_fe_cmd_arb_state_e;

  function automatic int fe_cmd_fifo_els(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 8;
      default:          return 8;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fe_cmd_rr_sel.sv
// rtl/bp_be_fe_cmd_rr_sel.sv - round-robin candidate picker
//
// Purpose: returns the first requester with its request bit set, searching
// upward from rr_ptr_i+1 and wrapping. Purely combinational.
// Ports:
//   req_i     request vector
//   rr_ptr_i  index of the most recently granted requester
//   idx_o     candidate index (0 when v_o is low)
//   v_o       any request present

module bp_be_fe_cmd_rr_sel
  import bp_be_pkg::*;
  #(parameter int num_req_p = 4
   ,localparam int idx_width_lp = `BSG_SAFE_CLOG2(num_req_p)
   )
  (input  logic [num_req_p-1:0]    req_i
  ,input  logic [idx_width_lp-1:0] rr_ptr_i
  ,output logic [idx_width_lp-1:0] idx_o
  ,output logic                    v_o
  );

  logic [idx_width_lp-1:0] probe;

  // Walk from the farthest position to the nearest so the last hit, which
  // wins, is the nearest requester after rr_ptr_i.
  always_comb begin
    idx_o = '0;
    v_o   = 1'b0;
    probe = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      probe = idx_width_lp'((int'(rr_ptr_i) + k) % num_req_p);
      if (req_i[probe]) begin
        idx_o = probe;
        v_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_be_fe_cmd_arbiter.sv
// rtl/bp_be_fe_cmd_arbiter.sv - credit-tracked round-robin arbiter into the FE command queue
//
// Purpose: picks one BE command source per cycle, enqueues it into the FE
// command queue only when a free entry is known to exist, and serialises
// fence commands (fence waits for an empty queue; nothing follows until the
// fence has been dequeued).
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   req_v_i          per-requester valid (held until granted)
//   req_cmd_i        packed per-requester commands, requester i in slice i
//   req_fence_i      per-requester fence marker
//   req_yumi_o       one-hot grant, same cycle as the enqueue
//   fe_cmd_o/_v_o    enqueue data/strobe to the queue
//   fe_cmd_deq_i     queue dequeue
//   credits_o        free queue entries
//   idle_o           RUN, queue empty, no requests

module bp_be_fe_cmd_arbiter
  import bp_be_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,parameter int num_req_p = 4
   ,localparam int fe_cmd_fifo_els_p = fe_cmd_fifo_els(bp_params_p)
   ,localparam int fe_cmd_width_lp   = $bits(bp_fe_cmd_s)
   ,localparam int cred_width_lp     = `BSG_SAFE_CLOG2(fe_cmd_fifo_els_p+1)
   ,localparam int idx_width_lp      = `BSG_SAFE_CLOG2(num_req_p)
   )
  (input  logic                                   clk_i
  ,input  logic                                   reset_i
  ,input  logic [num_req_p-1:0]                   req_v_i
  ,input  logic [num_req_p*fe_cmd_width_lp-1:0]   req_cmd_i
  ,input  logic [num_req_p-1:0]                   req_fence_i
  ,output logic [num_req_p-1:0]                   req_yumi_o
  ,output logic [fe_cmd_width_lp-1:0]             fe_cmd_o
  ,output logic                                   fe_cmd_v_o
  ,input  logic                                   fe_cmd_deq_i
  ,output logic [cred_width_lp-1:0]               credits_o
  ,output logic                                   idle_o
  );

  localparam logic [cred_width_lp-1:0] els_lp = cred_width_lp'(fe_cmd_fifo_els_p);

  bp_be_fe_cmd_arb_state_e   state_r;
  logic [cred_width_lp-1:0]  credits_r, credits_n;
  logic [idx_width_lp-1:0]   rr_ptr_r, fence_idx_r;
  logic [idx_width_lp-1:0]   cand_idx, grant_idx;
  logic                      cand_v, cand_fence, credits_full, grant_raw;
  logic [num_req_p-1:0]      grant_oh;
  logic [fe_cmd_width_lp-1:0] cmd_arr [num_req_p];

  bp_be_fe_cmd_rr_sel
   #(.num_req_p(num_req_p))
   rr_sel
    (.req_i   (req_v_i)
    ,.rr_ptr_i(rr_ptr_r)
    ,.idx_o   (cand_idx)
    ,.v_o     (cand_v)
    );

  for (genvar g = 0; g < num_req_p; g++) begin : cmd_slice
    assign cmd_arr[g] = req_cmd_i[g*fe_cmd_width_lp +: fe_cmd_width_lp];
  end

  assign cand_fence   = req_fence_i[cand_idx];
  assign credits_full = (credits_r == els_lp);

  // Grant decisions use registered credits only, so a dequeue never opens a
  // slot for an enqueue in the same cycle.
  always_comb begin
    grant_raw = 1'b0;
    grant_idx = cand_idx;
    case (state_r)
      e_run: begin
        if (cand_v)
          grant_raw = cand_fence ? credits_full : (credits_r != '0);
      end
      e_wait_empty: begin
        grant_idx = fence_idx_r;
        grant_raw = credits_full & req_v_i[fence_idx_r];
      end
      default: grant_raw = 1'b0;
    endcase
  end

  assign grant_oh   = num_req_p'(1) << grant_idx;
  assign req_yumi_o = (grant_raw & ~reset_i) ? grant_oh : '0;
  assign fe_cmd_v_o = |req_yumi_o;
  assign fe_cmd_o   = cmd_arr[grant_idx];
  assign credits_o  = credits_r;
  assign idle_o     = (state_r == e_run) & credits_full & ~(|req_v_i);

  assign credits_n = credits_r - cred_width_lp'(fe_cmd_v_o) + cred_width_lp'(fe_cmd_deq_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_run;
      credits_r   <= els_lp;
      rr_ptr_r    <= idx_width_lp'(num_req_p-1);
      fence_idx_r <= '0;
    end else begin
      credits_r <= credits_n;
      if (fe_cmd_v_o)
        rr_ptr_r <= grant_idx;
      case (state_r)
        e_run: begin
          if (grant_raw && cand_fence)
            state_r <= e_wait_deq;
          else if (cand_v && cand_fence && !credits_full) begin
            fence_idx_r <= cand_idx;
            state_r     <= e_wait_empty;
          end
        end
        e_wait_empty: begin
          if (grant_raw)
            state_r <= e_wait_deq;
        end
        e_wait_deq: begin
          // The fence went into an empty queue, so the first dequeue is it.
          if (fe_cmd_deq_i)
            state_r <= e_run;
        end
        default: state_r <= e_run;
      endcase
    end
  end

`ifndef SYNTHESIS
  `BP_BE_CRED_BOUNDS_ASSERT(clk_i, reset_i, credits_r, els_lp, fe_cmd_v_o, fe_cmd_deq_i)

  assert property (@(posedge clk_i) disable iff (reset_i)
    ((req_v_i & ~req_yumi_o) != '0) |=> (($past(req_v_i & ~req_yumi_o) & ~req_v_i) == '0));
`endif

endmodule
